// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one step per cycle.
module muldiv_iter #(
    parameter int unsigned XLEN         = 32,
    parameter bit          DZ_QUOT_ONES = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rt_i,
    input  logic            flush,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic            rd_sel,
    output logic [XLEN-1:0] rdata,
    output logic            busy,
    output logic            done,
    output logic            dz
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned ACC_W = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic               accept;
    logic [1:0]         op_q;
    logic [XLEN-1:0]    rs_q, rt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [XLEN-1:0]    rem_q;
    logic [XLEN-1:0]    hi_q, lo_q;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = start;
                if (start && !flush) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush)                            state_d = IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))   state_d = FIX;
            end
            FIX: begin
                busy    = 1'b1;
                done    = !flush;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-step datapath and final sign fix-up.
    logic              sgn, is_div, neg, div_zero;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [ACC_W-1:0]  acc_step, prod;
    logic [XLEN-1:0]   rem_step, quot, rem_s, res_hi, res_lo;

    always_comb begin
        sgn       = ~op_q[0];
        is_div    = op_q[1];
        a_mag     = mag(rs_q, sgn);
        b_mag     = mag(rt_q, sgn);
        neg       = sgn & (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
        div_zero  = (rt_q == '0);
        mul_sum   = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag} : '0);
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        if (is_div) begin
            acc_step = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
            rem_step = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
            rem_step = rem_q;
        end
        prod  = neg ? (~acc_q + ACC_W'(1)) : acc_q;
        quot  = neg ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
        rem_s = (sgn && rs_q[XLEN-1]) ? (~rem_q + XLEN'(1)) : rem_q;
        if (!is_div) begin
            res_hi = prod[ACC_W-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end else if (div_zero) begin
            res_hi = rs_q;
            res_lo = DZ_QUOT_ONES ? '1 : '0;
        end else begin
            res_hi = rem_s;
            res_lo = quot;
        end
    end

    // Operand latch, iteration state, HI/LO and sticky divide-by-zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            rem_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dz    <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op;
                rs_q  <= rs_i;
                rt_q  <= rt_i;
                cnt_q <= '0;
                rem_q <= '0;
                acc_q <= {XLEN'(0), op[1] ? mag(rs_i, ~op[0]) : mag(rt_i, ~op[0])};
                if (op[1]) dz <= 1'b0;
            end else if (state_q == CALC && !flush) begin
                cnt_q <= cnt_q + CNT_W'(1);
                acc_q <= acc_step;
                rem_q <= rem_step;
            end
            if (state_q == FIX && !flush) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
                if (is_div && div_zero) dz <= 1'b1;
            end
            if (state_q == IDLE && !start) begin
                if (wr_hi) hi_q <= wdata;
                if (wr_lo) lo_q <= wdata;
            end
        end
    end

    assign rdata = rd_sel ? hi_q : lo_q;

endmodule
